// File: rtl/timx_pwm_dtg_array.sv
// Complementary PWM output stage: shared edge/centre counter, preloaded compares, per-channel dead-time, break/MOE gating.
// Latency: ref registered 1 cycle after cnt; each output's rising edge is delayed dtg cycles; bkin gates outputs immediately.
// Backpressure: none, free-running. Define TIMX_PWM_REPCNT_EN to add the rcr repetition counter on update events.
module timx_pwm_dtg_array #(
   parameter int CNT_W = 16,
   parameter int NCH   = 4,
   parameter int DT_W  = 8
) (
   input  logic                 apb_clk,
   input  logic                 apb_rst_n,
   input  logic                 cen,
   input  logic                 cms,
   input  logic                 ug,
   input  logic [CNT_W-1:0]     arr,
   input  logic [NCH*CNT_W-1:0] ccr,
   input  logic [NCH-1:0]       ccxe,
   input  logic [NCH-1:0]       ccxne,
   input  logic [DT_W-1:0]      dtg,
   input  logic                 moe_set,
   input  logic                 bkin,
`ifdef TIMX_PWM_REPCNT_EN
   input  logic [7:0]           rcr,
`endif
   output logic [CNT_W-1:0]     cnt,
   output logic                 dir,
   output logic                 update,
   output logic                 moe,
   output logic [NCH-1:0]       ch_out,
   output logic [NCH-1:0]       chn_out
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

   logic [CNT_W-1:0]     arr_s;
   logic [NCH*CNT_W-1:0] ccr_s;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 dir_nxt;
   logic                 tev;
   logic                 upd_ev;
   logic [NCH-1:0]       dt_p_v;
   logic [NCH-1:0]       dt_n_v;

   // Next count and terminal event; only consumed when cen is high.
   always_comb begin
      cnt_nxt = cnt;
      dir_nxt = dir;
      tev     = 1'b0;
      if (!cms) begin
         dir_nxt = 1'b0;
         if (cnt >= arr_s) begin
            cnt_nxt = '0;
            tev     = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_ONE;
         end
      end else if (arr_s == '0) begin
         cnt_nxt = '0;
         dir_nxt = 1'b0;
         tev     = 1'b1;
      end else if (!dir) begin
         if (cnt >= arr_s) begin
            cnt_nxt = cnt - CNT_ONE;
            dir_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt + CNT_ONE;
            if (cnt + CNT_ONE == arr_s) begin
               dir_nxt = 1'b1;
               tev     = 1'b1;
            end
         end
      end else begin
         if (cnt <= CNT_ONE) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
            tev     = 1'b1;
         end else begin
            cnt_nxt = cnt - CNT_ONE;
         end
      end
   end

`ifdef TIMX_PWM_REPCNT_EN
   logic [7:0] rep;

   assign upd_ev = ug | (cen & tev & (rep == 8'd0));

   always_ff @(posedge apb_clk or negedge apb_rst_n) begin
      if (!apb_rst_n) begin
         rep <= 8'd0;
      end else if (ug) begin
         rep <= rcr;
      end else if (cen && tev) begin
         rep <= (rep == 8'd0) ? rcr : rep - 8'd1;
      end
   end
`else
   assign upd_ev = ug | (cen & tev);
`endif

   always_ff @(posedge apb_clk or negedge apb_rst_n) begin
      if (!apb_rst_n) begin
         cnt    <= '0;
         dir    <= 1'b0;
         update <= 1'b0;
         arr_s  <= '0;
         ccr_s  <= '0;
         moe    <= 1'b0;
      end else begin
         update <= upd_ev;
         if (ug) begin
            cnt <= '0;
            dir <= 1'b0;
         end else if (cen) begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
         end
         if (upd_ev) begin
            arr_s <= arr;
            ccr_s <= ccr;
         end
         // Break wins over a coincident MOE write.
         if (bkin) begin
            moe <= 1'b0;
         end else if (moe_set) begin
            moe <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CNT_W-1:0] ccr_i;
      logic             ref_nxt;
      logic             ref_q;
      logic [DT_W-1:0]  dt_cnt;
      logic             dt_p;
      logic             dt_n;

      assign ccr_i   = ccr_s[i*CNT_W +: CNT_W];
      assign ref_nxt = (cnt < ccr_i);

      // Any ref transition drops both sides, then the new active side waits out dtg.
      always_ff @(posedge apb_clk or negedge apb_rst_n) begin
         if (!apb_rst_n) begin
            ref_q  <= 1'b0;
            dt_cnt <= '0;
            dt_p   <= 1'b0;
            dt_n   <= 1'b0;
         end else begin
            ref_q <= ref_nxt;
            if (ref_nxt != ref_q) begin
               if (dtg == '0) begin
                  dt_p   <= ref_nxt;
                  dt_n   <= ~ref_nxt;
                  dt_cnt <= '0;
               end else begin
                  dt_p   <= 1'b0;
                  dt_n   <= 1'b0;
                  dt_cnt <= dtg;
               end
            end else if (dt_cnt > DT_ONE) begin
               dt_cnt <= dt_cnt - DT_ONE;
            end else begin
               dt_cnt <= '0;
               dt_p   <= ref_q;
               dt_n   <= ~ref_q;
            end
         end
      end

      assign dt_p_v[i] = dt_p;
      assign dt_n_v[i] = dt_n;
   end

   assign ch_out  = dt_p_v & ccxe  & {NCH{moe & ~bkin}};
   assign chn_out = dt_n_v & ccxne & {NCH{moe & ~bkin}};

endmodule

// File: tb/tb_timx_pwm_dtg_array.sv
// Randomised and directed bench for timx_pwm_dtg_array against a phase/run-length reference model.
`timescale 1ns/1ps
module tb_timx_pwm_dtg_array;
   localparam int CNT_W = 16;
   localparam int NCH   = 4;
   localparam int DT_W  = 8;

   logic                 apb_clk = 1'b0;
   logic                 apb_rst_n = 1'b0;
   logic                 cen = 1'b0, cms = 1'b0, ug = 1'b0, moe_set = 1'b0, bkin = 1'b0;
   logic [CNT_W-1:0]     arr = '0;
   logic [NCH*CNT_W-1:0] ccr = '0;
   logic [NCH-1:0]       ccxe = '0, ccxne = '0;
   logic [DT_W-1:0]      dtg = '0;
`ifdef TIMX_PWM_REPCNT_EN
   logic [7:0]           rcr = 8'd0;
`endif
   logic [CNT_W-1:0]     cnt;
   logic                 dir, update, moe;
   logic [NCH-1:0]       ch_out, chn_out;

   timx_pwm_dtg_array #(.CNT_W(CNT_W), .NCH(NCH), .DT_W(DT_W)) dut (
      .apb_clk(apb_clk), .apb_rst_n(apb_rst_n), .cen(cen), .cms(cms), .ug(ug),
      .arr(arr), .ccr(ccr), .ccxe(ccxe), .ccxne(ccxne), .dtg(dtg),
      .moe_set(moe_set), .bkin(bkin),
`ifdef TIMX_PWM_REPCNT_EN
      .rcr(rcr),
`endif
      .cnt(cnt), .dir(dir), .update(update), .moe(moe),
      .ch_out(ch_out), .chn_out(chn_out)
   );

   always #5 apb_clk = ~apb_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: counter as a phase within the period, dead-time as run lengths of ref.
   int m_ph, m_arr, m_rep;
   int m_ccr[NCH];
   int run_hi[NCH];
   int run_lo[NCH];
   bit m_moe, m_upd;

   function automatic int rcr_val();
`ifdef TIMX_PWM_REPCNT_EN
      return int'(rcr);
`else
      return 0;
`endif
   endfunction

   function automatic int m_cnt();
      if (cms && m_ph > m_arr) return 2 * m_arr - m_ph;
      return m_ph;
   endfunction

   function automatic bit m_dir();
      return cms && (m_arr > 0) && (m_ph >= m_arr);
   endfunction

   task automatic model_reset();
      m_ph = 0; m_arr = 0; m_rep = 0; m_moe = 0; m_upd = 0;
      for (int i = 0; i < NCH; i++) begin
         m_ccr[i] = 0; run_hi[i] = 0; run_lo[i] = 1000;
      end
   endtask

   task automatic model_load();
      m_arr = int'(arr);
      for (int i = 0; i < NCH; i++) m_ccr[i] = int'(ccr[i*CNT_W +: CNT_W]);
   endtask

   task automatic model_step();
      int c, per;
      bit term;
      c = m_cnt();
      for (int i = 0; i < NCH; i++) begin
         if (c < m_ccr[i]) begin run_hi[i]++; run_lo[i] = 0; end
         else begin run_lo[i]++; run_hi[i] = 0; end
      end
      m_upd = 0;
      if (ug) begin
         m_ph = 0; model_load(); m_upd = 1; m_rep = rcr_val();
      end else if (cen) begin
         per  = cms ? ((m_arr == 0) ? 1 : 2 * m_arr) : m_arr + 1;
         m_ph = (m_ph + 1) % per;
         term = (m_ph == 0) || (cms && m_ph == m_arr);
         if (term) begin
            if (m_rep == 0) begin m_upd = 1; model_load(); m_rep = rcr_val(); end
            else m_rep--;
         end
      end
      if (bkin) m_moe = 0;
      else if (moe_set) m_moe = 1;
   endtask

   task automatic check_outputs();
      logic [NCH-1:0] ech, echn;
      for (int i = 0; i < NCH; i++) begin
         ech[i]  = (run_hi[i] >= int'(dtg) + 1) && ccxe[i]  && m_moe && !bkin;
         echn[i] = (run_lo[i] >= int'(dtg) + 1) && ccxne[i] && m_moe && !bkin;
      end
      chk("cnt", 64'(cnt), 64'(m_cnt()));
      chk("dir", 64'(dir), 64'(m_dir()));
      chk("update", 64'(update), 64'(m_upd));
      chk("moe", 64'(moe), 64'(m_moe));
      chk("ch_out", 64'(ch_out), 64'(ech));
      chk("chn_out", 64'(chn_out), 64'(echn));
   endtask

   task automatic cyc();
      @(posedge apb_clk);
      model_step();
      #1;
      check_outputs();
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      @(negedge apb_clk);
      #2 apb_rst_n = 1'b0;
      cen = 0; ug = 0; moe_set = 0; bkin = 0; cms = 0;
`ifdef TIMX_PWM_REPCNT_EN
      rcr = 8'd0;
`endif
      #1;
      model_reset();
      check_outputs();
      @(negedge apb_clk);
      apb_rst_n = 1'b1;
   endtask

   task automatic setup(input bit c, input int a, input logic [NCH*CNT_W-1:0] cc, input int d);
      do_reset();
      cms = c; arr = CNT_W'(a); ccr = cc; dtg = DT_W'(d);
      ccxe = '1; ccxne = '1;
      ug = 1; moe_set = 1;
      cyc();
      ug = 0; moe_set = 0; cen = 1;
   endtask

   int n_ch, n_chn, n_upd;

   task automatic count_win(input int n);
      n_ch = 0; n_chn = 0; n_upd = 0;
      for (int k = 0; k < n; k++) begin
         cyc();
         n_ch  += int'(ch_out[0]);
         n_chn += int'(chn_out[0]);
         n_upd += int'(update);
      end
   endtask

   initial begin
      // 1: edge-aligned, 50% duty, no dead-time
      setup(1'b0, 15, {4{16'd8}}, 0);
      repeat (16) cyc();
      count_win(32);
      chk("s1_ch_hi", 64'(n_ch), 64'd16);
      chk("s1_chn_hi", 64'(n_chn), 64'd16);
      chk("s1_updates", 64'(n_upd), 64'd2);

      // 2: dead-time 3, then a pulse narrower than the dead-time
      setup(1'b0, 15, {4{16'd8}}, 3);
      repeat (16) cyc();
      count_win(32);
      chk("s2_ch_hi", 64'(n_ch), 64'd10);
      chk("s2_chn_hi", 64'(n_chn), 64'd10);
      ccr[15:0] = 16'd2;
      repeat (32) cyc();
      count_win(32);
      chk("s2_narrow_ch_hi", 64'(n_ch), 64'd0);

      // 3: centre-aligned
      setup(1'b1, 10, {4{16'd4}}, 0);
      repeat (20) cyc();
      count_win(40);
      chk("s3_updates", 64'(n_upd), 64'd4);

      // 4: arr change mid-period, then ug mid-count
      setup(1'b0, 15, {4{16'd8}}, 1);
      repeat (20) cyc();
      arr = 16'd31;
      repeat (40) cyc();
      count_win(64);
      chk("s4_updates", 64'(n_upd), 64'd2);
      repeat (7) cyc();
      ug = 1; cyc(); ug = 0;
      repeat (20) cyc();

      // 5: break with a coincident moe_set, then re-arm
      setup(1'b0, 15, {16'd3, 16'd12, 16'd0, 16'd8}, 2);
      repeat (20) cyc();
      bkin = 1; moe_set = 1;
      #1;
      chk("brk_ch_gate", 64'(ch_out), 64'd0);
      chk("brk_chn_gate", 64'(chn_out), 64'd0);
      cyc();
      bkin = 0; moe_set = 0;
      cyc();
      chk("brk_moe_low", 64'(moe), 64'd0);
      repeat (5) cyc();
      moe_set = 1; cyc(); moe_set = 0;
      repeat (20) cyc();

`ifdef TIMX_PWM_REPCNT_EN
      // 6: repetition counter
      do_reset();
      rcr = 8'd2;
      cms = 0; arr = 16'd7; ccr = {4{16'd4}}; dtg = '0; ccxe = '1; ccxne = '1;
      ug = 1; moe_set = 1; cyc(); ug = 0; moe_set = 0; cen = 1;
      repeat (24) cyc();
      count_win(48);
      chk("s6_updates", 64'(n_upd), 64'd2);
      ccr = {4{16'd2}};
      repeat (40) cyc();
`endif

      // Random scenarios; arr only changes mid-run in edge mode.
      for (int s = 0; s < 10; s++) begin
         int a, d;
         bit c;
         logic [NCH*CNT_W-1:0] cc;
         c = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 20);
         d = $urandom_range(0, 5);
         for (int i = 0; i < NCH; i++) cc[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, a + 2));
         do_reset();
`ifdef TIMX_PWM_REPCNT_EN
         rcr = 8'($urandom_range(0, 3));
`endif
         cms = c; arr = CNT_W'(a); ccr = cc; dtg = DT_W'(d);
         ccxe = NCH'($urandom); ccxne = NCH'($urandom);
         ug = 1; moe_set = 1; cyc(); ug = 0; moe_set = 0; cen = 1;
         for (int k = 0; k < 150; k++) begin
            cyc();
            ug      = ($urandom_range(0, 39) == 0);
            moe_set = ($urandom_range(0, 14) == 0);
            bkin    = ($urandom_range(0, 49) == 0);
            cen     = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 24) == 0) begin
               for (int i = 0; i < NCH; i++) ccr[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, a + 2));
            end
            if (!c && $urandom_range(0, 29) == 0) arr = CNT_W'($urandom_range(0, 20));
         end
         ug = 0; moe_set = 0; bkin = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
